id_ex_stage: RTL and testbench

- Execute-entry pipeline stage sitting directly upstream of the ALU.
- Registers decoded operands, register specifiers and ALU op code from decode once per cycle, honouring stall and flush.
- Drives the ALU's `a`, `b` and `aluSrc` inputs.
- With forwarding compiled in, resolves read-after-write hazards by selecting EX/MEM or MEM/WB results over stale register-file operands.

---
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU operands.
// Captures decoded operands, specifiers and op code once per cycle with
// flush-over-stall priority. Optional RAW forwarding from EX/MEM and MEM/WB
// is compiled in with the ID_EX_FORWARD_EN macro.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              idValid,
  input  logic [DATA_W-1:0] idRsData,
  input  logic [DATA_W-1:0] idRtData,
  input  logic [DATA_W-1:0] idImm,
  input  logic              idUseImm,
  input  logic [OP_W-1:0]   idAluSrc,
  input  logic [REG_W-1:0]  idRs,
  input  logic [REG_W-1:0]  idRt,
  input  logic [REG_W-1:0]  idRd,
  input  logic              idRegWrite,
  input  logic              exmemRegWrite,
  input  logic [REG_W-1:0]  exmemRd,
  input  logic [DATA_W-1:0] exmemResult,
  input  logic              memwbRegWrite,
  input  logic [REG_W-1:0]  memwbRd,
  input  logic [DATA_W-1:0] memwbResult,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [OP_W-1:0]   aluSrc,
  output logic [DATA_W-1:0] exRtData,
  output logic [REG_W-1:0]  exRd,
  output logic              exRegWrite,
  output logic              exValid
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              use_imm_q, use_imm_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              reg_write_q, reg_write_d;

  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // Next-state: flush loads a bubble, stall holds, otherwise capture decode.
  always_comb begin
    valid_d     = valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    op_d        = op_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      use_imm_d   = 1'b0;
      op_d        = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = idValid;
      rs_data_d   = idRsData;
      rt_data_d   = idRtData;
      imm_d       = idImm;
      use_imm_d   = idUseImm;
      op_d        = idAluSrc;
      rs_d        = idRs;
      rt_d        = idRt;
      rd_d        = idRd;
      reg_write_d = idRegWrite & idValid;
    end
  end

  // Stage registers with synchronous active-low reset to the bubble state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Operand forwarding: MEM/WB first, then EX/MEM overrides so the younger result wins.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (memwbRegWrite && (memwbRd == rs_q) && (rs_q != '0)) fwd_rs = memwbResult;
    if (exmemRegWrite && (exmemRd == rs_q) && (rs_q != '0)) fwd_rs = exmemResult;
    if (memwbRegWrite && (memwbRd == rt_q) && (rt_q != '0)) fwd_rt = memwbResult;
    if (exmemRegWrite && (exmemRd == rt_q) && (rt_q != '0)) fwd_rt = exmemResult;
  end
`else
  // No forwarding: operands come straight from the captured register-file data.
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
  end

  // Writeback ports stay on the interface but have no effect in this build.
  logic unused_fwd_ports;
  assign unused_fwd_ports = ^{exmemRegWrite, exmemRd, exmemResult,
                              memwbRegWrite, memwbRd, memwbResult, rs_q, rt_q};
`endif

  // ALU-facing outputs.
  always_comb begin
    a          = fwd_rs;
    b          = use_imm_q ? imm_q : fwd_rt;
    exRtData   = fwd_rt;
    aluSrc     = op_q;
    exRd       = rd_q;
    exValid    = valid_q;
    exRegWrite = reg_write_q & valid_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table followed by
// randomized stimulus checked against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, idValid, idUseImm, idRegWrite;
  logic [31:0] idRsData, idRtData, idImm;
  logic [4:0]  idAluSrc, idRs, idRt, idRd;
  logic        exmemRegWrite, memwbRegWrite;
  logic [4:0]  exmemRd, memwbRd;
  logic [31:0] exmemResult, memwbResult;
  logic [31:0] a, b, exRtData;
  logic [4:0]  aluSrc, exRd;
  logic        exRegWrite, exValid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .idValid(idValid),
    .idRsData(idRsData), .idRtData(idRtData), .idImm(idImm), .idUseImm(idUseImm),
    .idAluSrc(idAluSrc), .idRs(idRs), .idRt(idRt), .idRd(idRd), .idRegWrite(idRegWrite),
    .exmemRegWrite(exmemRegWrite), .exmemRd(exmemRd), .exmemResult(exmemResult),
    .memwbRegWrite(memwbRegWrite), .memwbRd(memwbRd), .memwbResult(memwbResult),
    .a(a), .b(b), .aluSrc(aluSrc), .exRtData(exRtData), .exRd(exRd),
    .exRegWrite(exRegWrite), .exValid(exValid)
  );

  typedef struct {
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] rs_data, rt_data, imm;
    logic        use_imm;
    logic [4:0]  op, rs, rt, rd;
    logic        reg_write;
    logic        xm_we;
    logic [4:0]  xm_rd;
    logic [31:0] xm_res;
    logic        mw_we;
    logic [4:0]  mw_rd;
    logic [31:0] mw_res;
    logic [31:0] e_a, e_b, e_rt;
    logic [4:0]  e_op, e_rd;
    logic        e_we, e_valid;
  } vec_t;

  // Behavioural model of the held instruction.
  typedef struct {
    bit        valid, use_imm, we;
    bit [31:0] rs_data, rt_data, imm;
    bit [4:0]  op, rs, rt, rd;
  } inst_t;
  inst_t m;

  localparam int NV = 16;
  vec_t tbl[NV];

  function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FORWARD_EN
    if (r != 0 && exmemRegWrite && exmemRd == r) return exmemResult;
    if (r != 0 && memwbRegWrite && memwbRd == r) return memwbResult;
`endif
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; stall = v.stall; flush = v.flush; idValid = v.id_valid;
    idRsData = v.rs_data; idRtData = v.rt_data; idImm = v.imm; idUseImm = v.use_imm;
    idAluSrc = v.op; idRs = v.rs; idRt = v.rt; idRd = v.rd; idRegWrite = v.reg_write;
    exmemRegWrite = v.xm_we; exmemRd = v.xm_rd; exmemResult = v.xm_res;
    memwbRegWrite = v.mw_we; memwbRd = v.mw_rd; memwbResult = v.mw_res;
  endtask

  // One clock edge: advance the model from the inputs presented, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) m = '{default: 0};
    else if (!stall) begin
      m.valid = idValid; m.rs_data = idRsData; m.rt_data = idRtData; m.imm = idImm;
      m.use_imm = idUseImm; m.op = idAluSrc; m.rs = idRs; m.rt = idRt; m.rd = idRd;
      m.we = idRegWrite && idValid;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ea, eb, ert;
    ea  = model_fwd(m.rs, m.rs_data);
    ert = model_fwd(m.rt, m.rt_data);
    eb  = m.use_imm ? m.imm : ert;
    chk({tag, ".a"}, a, ea);
    chk({tag, ".b"}, b, eb);
    chk({tag, ".exRtData"}, exRtData, ert);
    chk({tag, ".aluSrc"}, {27'd0, aluSrc}, {27'd0, m.op});
    chk({tag, ".exRd"}, {27'd0, exRd}, {27'd0, m.rd});
    chk({tag, ".exRegWrite"}, {31'd0, exRegWrite}, {31'd0, m.we && m.valid});
    chk({tag, ".exValid"}, {31'd0, exValid}, {31'd0, m.valid});
  endtask

  initial begin
    vec_t v;
    m = '{default: 0};

    // Reset for two cycles with live decode inputs.
    tbl[0]  = '{default: 0, rst_n: 0, id_valid: 1, rs_data: 32'h1234, rt_data: 32'h55, op: 5'd7, rs: 5'd1, rt: 5'd2, rd: 5'd3, reg_write: 1};
    tbl[1]  = '{default: 0, rst_n: 0, id_valid: 1, rs_data: 32'hdead, rt_data: 32'hbeef, op: 5'd9, rs: 5'd3, rt: 5'd4, rd: 5'd6, reg_write: 1};
    // Plain capture.
    tbl[2]  = '{default: 0, rst_n: 1, id_valid: 1, rs_data: 32'h5, rt_data: 32'h3, op: 5'b00010, rs: 5'd1, rt: 5'd2, rd: 5'd8, reg_write: 1,
                e_a: 32'h5, e_b: 32'h3, e_rt: 32'h3, e_op: 5'b00010, e_rd: 5'd8, e_we: 1, e_valid: 1};
    // Immediate selects b, store data still rt.
    tbl[3]  = '{default: 0, rst_n: 1, id_valid: 1, rs_data: 32'h5, rt_data: 32'h11, imm: 32'hFFFFFFFC, use_imm: 1, op: 5'd3, rs: 5'd1, rt: 5'd2, rd: 5'd9, reg_write: 1,
                e_a: 32'h5, e_b: 32'hFFFFFFFC, e_rt: 32'h11, e_op: 5'd3, e_rd: 5'd9, e_we: 1, e_valid: 1};
    // Three stall cycles with changing decode inputs.
    for (int i = 4; i < 7; i++)
      tbl[i] = '{default: 0, rst_n: 1, stall: 1, id_valid: i[0], rs_data: 32'h99 + i, rt_data: 32'h77, op: 5'h1F, rs: 5'd6, rt: 5'd7, rd: 5'd1, reg_write: 1,
                 e_a: 32'h5, e_b: 32'hFFFFFFFC, e_rt: 32'h11, e_op: 5'd3, e_rd: 5'd9, e_we: 1, e_valid: 1};
    // Flush with stall: flush wins.
    tbl[7]  = '{default: 0, rst_n: 1, stall: 1, flush: 1, id_valid: 1, rs_data: 32'h42, op: 5'd5, rd: 5'd2, reg_write: 1};
    // Capture rs=rt=4, no writeback activity.
    tbl[8]  = '{default: 0, rst_n: 1, id_valid: 1, rs_data: 32'h10, rt_data: 32'h20, op: 5'd4, rs: 5'd4, rt: 5'd4, rd: 5'd5, reg_write: 1,
                e_a: 32'h10, e_b: 32'h20, e_rt: 32'h20, e_op: 5'd4, e_rd: 5'd5, e_we: 1, e_valid: 1};
    // Held while both writeback stages target r4, then EX/MEM drops out.
    tbl[9]  = '{default: 0, rst_n: 1, stall: 1, xm_we: 1, xm_rd: 5'd4, xm_res: 32'hAA, mw_we: 1, mw_rd: 5'd4, mw_res: 32'hBB,
`ifdef ID_EX_FORWARD_EN
                e_a: 32'hAA, e_b: 32'hAA, e_rt: 32'hAA,
`else
                e_a: 32'h10, e_b: 32'h20, e_rt: 32'h20,
`endif
                e_op: 5'd4, e_rd: 5'd5, e_we: 1, e_valid: 1};
    tbl[10] = '{default: 0, rst_n: 1, stall: 1, xm_we: 0, xm_rd: 5'd4, xm_res: 32'hAA, mw_we: 1, mw_rd: 5'd4, mw_res: 32'hBB,
`ifdef ID_EX_FORWARD_EN
                e_a: 32'hBB, e_b: 32'hBB, e_rt: 32'hBB,
`else
                e_a: 32'h10, e_b: 32'h20, e_rt: 32'h20,
`endif
                e_op: 5'd4, e_rd: 5'd5, e_we: 1, e_valid: 1};
    // Register 0 is never forwarded.
    tbl[11] = '{default: 0, rst_n: 1, id_valid: 1, rs_data: 32'h33, rt_data: 32'h44, op: 5'd6, rs: 5'd0, rt: 5'd0, rd: 5'd7, reg_write: 1,
                xm_we: 1, xm_rd: 5'd0, xm_res: 32'hAA, mw_we: 1, mw_rd: 5'd0, mw_res: 32'hBB,
                e_a: 32'h33, e_b: 32'h44, e_rt: 32'h44, e_op: 5'd6, e_rd: 5'd7, e_we: 1, e_valid: 1};
    // Invalid slot keeps op code but never writes.
    tbl[12] = '{default: 0, rst_n: 1, id_valid: 0, rs_data: 32'h1, rt_data: 32'h2, op: 5'h0A, rs: 5'd1, rt: 5'd2, rd: 5'd3, reg_write: 1,
                e_a: 32'h1, e_b: 32'h2, e_rt: 32'h2, e_op: 5'h0A, e_rd: 5'd3, e_we: 0, e_valid: 0};
    // Reset during stall wins.
    tbl[13] = '{default: 0, rst_n: 0, stall: 1, id_valid: 1, rs_data: 32'h9, op: 5'd1, rd: 5'd4, reg_write: 1};
    tbl[14] = '{default: 0, rst_n: 1, id_valid: 1, rs_data: 32'h7, rt_data: 32'h8, op: 5'd12, rs: 5'd9, rt: 5'd10, rd: 5'd11, reg_write: 1,
                e_a: 32'h7, e_b: 32'h8, e_rt: 32'h8, e_op: 5'd12, e_rd: 5'd11, e_we: 1, e_valid: 1};
    // Flush alone loads a bubble.
    tbl[15] = '{default: 0, rst_n: 1, flush: 1, id_valid: 1, rs_data: 32'h3, op: 5'd2, rs: 5'd1, rd: 5'd2, reg_write: 1};

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      v = tbl[i];
      apply(v);
      tick();
      chk($sformatf("v%0d.a", i), a, v.e_a);
      chk($sformatf("v%0d.b", i), b, v.e_b);
      chk($sformatf("v%0d.exRtData", i), exRtData, v.e_rt);
      chk($sformatf("v%0d.aluSrc", i), {27'd0, aluSrc}, {27'd0, v.e_op});
      chk($sformatf("v%0d.exRd", i), {27'd0, exRd}, {27'd0, v.e_rd});
      chk($sformatf("v%0d.exRegWrite", i), {31'd0, exRegWrite}, {31'd0, v.e_we});
      chk($sformatf("v%0d.exValid", i), {31'd0, exValid}, {31'd0, v.e_valid});
    end

    // Randomized traffic; small register range forces frequent hazards.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      idValid = ($urandom_range(0, 4) != 0);
      idRsData = $urandom; idRtData = $urandom; idImm = $urandom;
      idUseImm = $urandom_range(0, 1);
      idAluSrc = 5'($urandom);
      idRs = 5'($urandom_range(0, 3)); idRt = 5'($urandom_range(0, 3));
      idRd = 5'($urandom); idRegWrite = $urandom_range(0, 1);
      exmemRegWrite = $urandom_range(0, 1); exmemRd = 5'($urandom_range(0, 3)); exmemResult = $urandom;
      memwbRegWrite = $urandom_range(0, 1); memwbRd = 5'($urandom_range(0, 3)); memwbResult = $urandom;
      tick();
      check_model($sformatf("r%0d", i));
      // Forwarding ports change mid-cycle; operands must follow combinationally.
      exmemRegWrite = $urandom_range(0, 1); exmemRd = 5'($urandom_range(0, 3)); exmemResult = $urandom;
      memwbRegWrite = $urandom_range(0, 1); memwbRd = 5'($urandom_range(0, 3)); memwbResult = $urandom;
      #1;
      check_model($sformatf("r%0d.mid", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
